// File: rtl/ustoch_pkg.sv
// Shared definitions for the unipolar stochastic readout path: FSM state
// encoding, default window sizing and result-width helpers.
package ustoch_pkg;

    // Converter FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } ustate_e;

    // Default counter width; the window is 2^DEF_BITWIDTH cycles long
    localparam int DEF_BITWIDTH = 8;

    // Window length in cycles for a given counter width
    function automatic int win_len(input int bw);
        return 32'sd1 << bw;
    endfunction

    // A full window of ones must be representable exactly, hence one extra bit
    function automatic int res_width(input int bw);
        return bw + 32'sd1;
    endfunction

    localparam int WIN_LEN = win_len(DEF_BITWIDTH);

endpackage

// File: rtl/uwin_cnt.sv
// Window counter for the stochastic-to-binary converter. Counts enabled
// cycles, wraps naturally at 2^BITWIDTH, and flags the final cycle of a window.
module uwin_cnt
    import ustoch_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [BITWIDTH-1:0] LAST_IDX = BITWIDTH'(win_len(BITWIDTH) - 32'sd1);

    logic [BITWIDTH-1:0] cnt_q;
    logic [BITWIDTH-1:0] cnt_d;

    // Next count: clear has priority, otherwise advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + BITWIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/ubit2bin_cnt.sv
// Unipolar stochastic-to-binary converter: counts ones in a serial bitstream
// over a 2^BITWIDTH-cycle window and presents the count with a valid/ack
// handshake plus a sticky overwrite flag.
// Optional macro UBIT2BIN_CONTINUOUS_EN: when defined, iStart held high at a
// window end starts the next window immediately (back-to-back windows).
module ubit2bin_cnt
    import ustoch_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                             iClk,
    input  logic                             iRstN,
    input  logic                             iBit,
    input  logic                             iStart,
    input  logic                             iAck,
    output logic                             oBusy,
    output logic [res_width(BITWIDTH)-1:0]   oVal,
    output logic                             oValid,
    output logic                             oOvf
);

    localparam int RW = res_width(BITWIDTH);

    ustate_e          state_q, state_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [RW-1:0]    val_q, val_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             win_clr_s;
    logic             win_en_s;
    logic             win_last_s;
    logic [RW-1:0]    bit_ext_s;

    assign bit_ext_s = {{BITWIDTH{1'b0}}, iBit};

    uwin_cnt #(
        .BITWIDTH (BITWIDTH)
    ) u_win (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .clr_i  (win_clr_s),
        .en_i   (win_en_s),
        .last_o (win_last_s)
    );

    // Next-state, accumulator and result/handshake logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        val_d     = val_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        win_clr_s = 1'b0;
        win_en_s  = 1'b0;

        // Consumer acknowledge; a coinciding window end overrides below
        if (valid_q && iAck) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d   = ST_COUNT;
                    win_clr_s = 1'b1;
                    acc_d     = '0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_COUNT: begin
                win_en_s = 1'b1;
                if (win_last_s) begin
                    // The final bit is folded straight into the result
                    val_d   = acc_q + bit_ext_s;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    if (valid_q && !iAck) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
`ifdef UBIT2BIN_CONTINUOUS_EN
                    if (iStart) begin
                        state_d = ST_COUNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    acc_d = acc_q + bit_ext_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial window
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oBusy  = (state_q == ST_COUNT);
    assign oVal   = val_q;
    assign oValid = valid_q;
    assign oOvf   = ovf_q;

endmodule

// File: doc/ubit2bin_cnt.md
# ubit2bin_cnt

Unipolar stochastic-to-binary converter for the scaled-adder datapath. Counts the ones in a serial unipolar bitstream, such as the output of the scaled adder, over a fixed window of 2^BITWIDTH cycles. It then presents the count as a binary value with a valid/ack handshake. It sits directly downstream of the adder and closes the binary → stochastic → binary loop for result readout and verification.

## Interface
- BITWIDTH, 8: window length is 2^BITWIDTH cycles; result width is BITWIDTH+1.
- iClk  in  1  clock, rising edge.
- iRstN  in  1  asynchronous, active-low reset.
- iBit  in  1  stochastic bit, sampled every COUNT cycle.
- iStart  in  1  request a conversion window.
- iAck  in  1  consumer has taken oVal.
- oBusy  out  1  high in COUNT.
- oVal  out  BITWIDTH+1  ones count of the last completed window, range 0..2^BITWIDTH.
- oValid  out  1  oVal holds an unconsumed result.
- oOvf  out  1  sticky; a result was overwritten before it was acknowledged.

## Operation
- FSM states: IDLE and COUNT.
- IDLE:
  - oBusy=0.
  - If iStart=1 at an edge: go to COUNT, clear the window counter and the ones accumulator.
- COUNT:
  - oBusy=1.
  - Each edge: accumulator += iBit; window counter += 1.
  - iStart is ignored.
- Window end: the edge at which the window counter equals 2^BITWIDTH−1.
  - oVal ← accumulator + iBit.
  - oValid ← 1.
  - State → IDLE, unless the configuration feature applies.
- Accumulator is BITWIDTH+1 bits wide and never wraps; the maximum value 2^BITWIDTH is exact.
- Window counter is BITWIDTH bits and wraps to 0 at window end.
- Handshake:
  - oValid falls at the edge where oValid=1 and iAck=1.
  - iAck while oValid=0 has no effect.
- Simultaneous window end and iAck: the new result loads, oValid stays 1, and oOvf is unchanged.
- Window end while oValid=1 and iAck=0: oVal is overwritten, oValid stays 1, and oOvf ← 1.
- oOvf is cleared only by reset.
- Reset at any time, including mid-window:
  - State → IDLE.
  - Counters, oVal, oValid, oBusy and oOvf all → 0.
  - The partial window is discarded.

## Timing
- iStart sampled at edge T0 → COUNT from T0.
  - First sampled bit is at edge T0+1.
  - Last sampled bit is at edge T0+2^BITWIDTH, which is also the edge that sets oValid.
  - Latency: oValid high in the cycle after edge T0+2^BITWIDTH, i.e. 2^BITWIDTH+1 cycles after the start request.
- oBusy falls at the same edge oValid rises (one-shot mode).
- The earliest next start is an iStart sampled at that same edge's following cycle. There is one IDLE cycle between windows in one-shot mode.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: UBIT2BIN_CONTINUOUS_EN.
- Defined: at window end, if iStart=1 on that edge, stay in COUNT.
  - The accumulator restarts from 0 and the window counter from 0.
  - No gap cycle: windows are back-to-back and oValid rises every 2^BITWIDTH cycles.
  - If iStart=0, go to IDLE as usual.
- Undefined: always return to IDLE at window end; iStart on that edge is ignored.

## Structure
- Shared package ustoch_pkg holds:
  - state typedef (IDLE, COUNT);
  - localparam for window length 2^BITWIDTH;
  - result-width function BITWIDTH+1.
- One sub-module: uwin_cnt, the BITWIDTH-bit window counter with clear and a last-cycle flag output.
- The FSM, accumulator and output register stay in the top module.

## Test plan
- BITWIDTH=8, iBit=1 constant, pulse iStart:
  - oValid rises 257 cycles later with oVal=256;
  - oBusy high for exactly 256 cycles.
- iBit=0 constant → oVal=0, oValid=1, oOvf=0.
- iBit alternating 1,0 from the first sampled cycle → oVal=128. iAck held 1 cycle → oValid=0 on the next cycle.
- Two windows, no iAck after the first (first all-ones, second all-zeros) → oVal=0, oValid=1, oOvf=1. Repeat with iAck coincident with the second window end → oOvf=0.
- Assert iRstN=0 at cycle 100 of a window → all outputs 0 immediately. After release, iStart with all-ones → oVal=256 with no residue from the aborted window.
- UBIT2BIN_CONTINUOUS_EN defined, iStart held 1, iBit=1 → oValid rises every 256 cycles, oVal=256 each time, oBusy never drops. Drop iStart before a window end → IDLE after that window.
